// File: rtl/i2c_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2c_fifo
// Purpose  : Synchronous show-ahead FIFO placed between the APB bridge and the
//            I2C core (one instance for TX, one for RX). The head word is
//            presented combinationally on RD_DATA, so a bridge read completes
//            in the same cycle it is issued.
// Ports    : PCLK        - clock, rising edge
//            PRESET      - asynchronous reset, active-high
//            CLEAR       - synchronous flush (sticky errors preserved)
//            ERR_CLR     - synchronous clear of OVERFLOW/UNDERFLOW
//            WR_EN/WR_DATA - push request and data
//            RD_EN       - pop request
//            RD_DATA     - head word, 0 while EMPTY
//            EMPTY/FULL/ALMOST_FULL/COUNT - occupancy status
//            OVERFLOW/UNDERFLOW - sticky refused-push / refused-pop flags
// Revision : 1.0 - initial release
// ============================================================================
module i2c_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter int AF_THR = 12
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              CLEAR,
    input  logic              ERR_CLR,
    input  logic              WR_EN,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              RD_EN,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic [AWIDTH:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int              c_DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] c_PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] c_AF_THR  = (AWIDTH + 1)'(AF_THR);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the low (index) bits coincide.
    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic [DWIDTH-1:0] r_mem [c_DEPTH];
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [AWIDTH:0]   w_count;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Status is a pure function of the registered pointers.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]) &&
                     (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]);
    // Modular difference of the extended pointers is the occupancy 0..depth.
    assign w_count = r_wr_ptr - r_rd_ptr;

    // A pop in the same cycle frees a slot, so a push at FULL still lands.
    assign w_rd_acc  = RD_EN && !w_empty;
    assign w_wr_acc  = WR_EN && (!w_full || w_rd_acc);
    assign w_ovf_set = WR_EN && w_full && !w_rd_acc;
    assign w_udf_set = RD_EN && w_empty;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (CLEAR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is deliberately left unreset; RD_DATA is masked while empty.
    always_ff @(posedge PCLK) begin
        if (w_wr_acc && !CLEAR) begin
            r_mem[r_wr_ptr[AWIDTH-1:0]] <= WR_DATA;
        end
    end

    // Sticky errors: a set event in the same cycle beats ERR_CLR.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !ERR_CLR) || w_ovf_set;
            r_underflow <= (r_underflow && !ERR_CLR) || w_udf_set;
        end
    end

    assign RD_DATA     = w_empty ? '0 : r_mem[r_rd_ptr[AWIDTH-1:0]];
    assign EMPTY       = w_empty;
    assign FULL        = w_full;
    assign COUNT       = w_count;
    assign ALMOST_FULL = (w_count >= c_AF_THR);
    assign OVERFLOW    = r_overflow;
    assign UNDERFLOW   = r_underflow;

endmodule
`default_nettype wire
